button_event_unit: RTL and testbench

Front-end conditioner for the five board pushbuttons (U, D, R, L, C) in the digital clock design. It synchronises and debounces each raw button and produces single-cycle, one-hot press events. The U and D buttons auto-repeat while held, for fast time/alarm setting. Its btn_event vector drives the clock controller's 5-bit button-code input directly, replacing the per-button edge detectors.

---
 rtl/btn_pkg.sv | 26 ++
 rtl/btn_debounce.sv | 54 +++++
 rtl/button_event_unit.sv | 165 ++++++++++++++++
 tb/tb_button_event_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// btn_pkg: shared constants and types for the pushbutton front end.
// Bit order of every button vector is {U,D,R,L,C}.
package btn_pkg;

    localparam int unsigned NUM_BTN = 5;

    localparam int unsigned BTN_C = 0;
    localparam int unsigned BTN_L = 1;
    localparam int unsigned BTN_R = 2;
    localparam int unsigned BTN_D = 3;
    localparam int unsigned BTN_U = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        HOLD_WAIT = 2'b01,
        REPEAT    = 2'b10
    } rep_state_e;

    function automatic int unsigned max_u(
        input int unsigned a,
        input int unsigned b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchroniser followed by a run-length debouncer.
// The stable level only flips after DEBOUNCE_TICKS consecutive differing samples.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS = 4
) (
    input  logic clk_200_hz,
    input  logic rst,
    input  logic btn_raw,
    output logic level
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_ff @(posedge clk_200_hz or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    // Any sample agreeing with the stable level restarts the run.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = ~level_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign level = level_q;

endmodule

// File: rtl/button_event_unit.sv
// button_event_unit: debounced one-hot press events for the five pushbuttons,
// with hold-to-repeat on the masked buttons and fixed C>L>R>D>U priority.
module button_event_unit
    import btn_pkg::*;
#(
    parameter int unsigned        DEBOUNCE_TICKS = 4,
    parameter int unsigned        REPEAT_DELAY   = 100,
    parameter int unsigned        REPEAT_RATE    = 20,
    parameter logic [NUM_BTN-1:0] REPEAT_MASK    =
        NUM_BTN'((1 << BTN_U) | (1 << BTN_D))
) (
    input  logic               clk_200_hz,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_event,
    output logic [NUM_BTN-1:0] btn_level,
    output logic               any_event
);

    localparam int unsigned RPT_W =
        $clog2(max_u(REPEAT_DELAY, REPEAT_RATE) + 1);
    localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

    if (DEBOUNCE_TICKS < 1) begin : g_bad_debounce
        $error("DEBOUNCE_TICKS must be at least 1");
    end
    if (REPEAT_RATE < 1) begin : g_bad_rate
        $error("REPEAT_RATE must be at least 1");
    end
    if (REPEAT_DELAY < REPEAT_RATE) begin : g_bad_delay
        $error("REPEAT_DELAY must not be below REPEAT_RATE");
    end

    logic [NUM_BTN-1:0] stable;
    logic [NUM_BTN-1:0] press_cand;
    logic [NUM_BTN-1:0] rpt_cand;
    logic [NUM_BTN-1:0] cand;
    logic [NUM_BTN-1:0] win;

    logic [NUM_BTN-1:0] btn_event_q;
    logic [NUM_BTN-1:0] btn_event_d;
    logic [NUM_BTN-1:0] btn_level_q;
    logic [NUM_BTN-1:0] btn_level_d;
    logic               any_event_q;
    logic               any_event_d;

    // The registered level doubles as the previous-cycle stable level.
    assign press_cand = stable & ~btn_level_q;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn

        btn_debounce #(
            .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
        ) u_debounce (
            .clk_200_hz(clk_200_hz),
            .rst       (rst),
            .btn_raw   (btn_raw[i]),
            .level     (stable[i])
        );

        if (REPEAT_MASK[i]) begin : g_rpt

            rep_state_e       state_q;
            rep_state_e       state_d;
            logic [RPT_W-1:0] cnt_q;
            logic [RPT_W-1:0] cnt_d;
            logic             rpt_d;

            always_ff @(posedge clk_200_hz or posedge rst) begin
                if (rst) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                end
            end

            // Runs independently of arbitration; a lost repeat is not retried.
            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                rpt_d   = 1'b0;
                unique case (state_q)
                    IDLE: begin
                        if (press_cand[i]) begin
                            state_d = HOLD_WAIT;
                            cnt_d   = '0;
                        end
                    end
                    HOLD_WAIT: begin
                        if (!stable[i]) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else if (cnt_q == DELAY_LAST) begin
                            rpt_d   = 1'b1;
                            state_d = REPEAT;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + RPT_W'(1);
                        end
                    end
                    REPEAT: begin
                        if (!stable[i]) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else if (cnt_q == RATE_LAST) begin
                            rpt_d = 1'b1;
                            cnt_d = '0;
                        end else begin
                            cnt_d = cnt_q + RPT_W'(1);
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                endcase
            end

            assign rpt_cand[i] = rpt_d;

        end else begin : g_no_rpt
            assign rpt_cand[i] = 1'b0;
        end
    end

    assign cand = press_cand | rpt_cand;

    always_comb begin
        win = '0;
        priority case (1'b1)
            cand[BTN_C]: win[BTN_C] = 1'b1;
            cand[BTN_L]: win[BTN_L] = 1'b1;
            cand[BTN_R]: win[BTN_R] = 1'b1;
            cand[BTN_D]: win[BTN_D] = 1'b1;
            cand[BTN_U]: win[BTN_U] = 1'b1;
            default:     win = '0;
        endcase
    end

    always_comb begin
        btn_event_d = win;
        btn_level_d = stable;
        any_event_d = |win;
    end

    always_ff @(posedge clk_200_hz or posedge rst) begin
        if (rst) begin
            btn_event_q <= '0;
            btn_level_q <= '0;
            any_event_q <= 1'b0;
        end else begin
            btn_event_q <= btn_event_d;
            btn_level_q <= btn_level_d;
            any_event_q <= any_event_d;
        end
    end

    assign btn_event = btn_event_q;
    assign btn_level = btn_level_q;
    assign any_event = any_event_q;

endmodule

// File: tb/tb_button_event_unit.sv
// tb_button_event_unit: random and directed button activity against a
// history-window reference model, compared cycle by cycle via a queue.
module tb_button_event_unit;

    localparam int DEB      = 4;
    localparam int RDELAY   = 100;
    localparam int RRATE    = 20;
    localparam logic [4:0] RPT_MASK = 5'b11000;

    localparam logic [4:0] B_C = 5'b00001;
    localparam logic [4:0] B_L = 5'b00010;
    localparam logic [4:0] B_R = 5'b00100;
    localparam logic [4:0] B_D = 5'b01000;
    localparam logic [4:0] B_U = 5'b10000;

    logic       clk_200_hz;
    logic       rst;
    logic [4:0] btn_raw;
    logic [4:0] btn_event;
    logic [4:0] btn_level;
    logic       any_event;

    button_event_unit #(
        .DEBOUNCE_TICKS(DEB),
        .REPEAT_DELAY  (RDELAY),
        .REPEAT_RATE   (RRATE),
        .REPEAT_MASK   (RPT_MASK)
    ) dut (
        .clk_200_hz(clk_200_hz),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .btn_event (btn_event),
        .btn_level (btn_level),
        .any_event (any_event)
    );

    initial clk_200_hz = 1'b0;
    always #5 clk_200_hz = ~clk_200_hz;

    typedef struct packed {
        logic [4:0] ev;
        logic [4:0] lv;
        logic       any;
    } exp_t;

    exp_t expq[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   evt_seen [5];

    // Reference model: raw samples kept as a history window, newest first.
    logic [4:0] hist [0:DEB];
    logic [4:0] m_stable;
    logic [4:0] m_level;
    int         press_at [5];
    int         cyc = 0;

    always @(posedge clk_200_hz) begin
        logic [4:0] cand;
        logic [4:0] win;
        logic [4:0] st_new;
        exp_t       e;
        bit         flip;
        cyc++;
        if (rst) begin
            for (int j = 0; j <= DEB; j++) hist[j] = '0;
            for (int b = 0; b < 5; b++) press_at[b] = -1;
            m_stable = '0;
            m_level  = '0;
            e = '0;
        end else begin
            cand   = '0;
            st_new = m_stable;
            for (int b = 0; b < 5; b++) begin
                // Synchronised value seen in the cycle before edge k is raw at k-2.
                flip = 1'b1;
                for (int j = 1; j <= DEB; j++)
                    if (hist[j][b] == m_stable[b]) flip = 1'b0;
                if (flip) st_new[b] = ~m_stable[b];
                if (m_stable[b] && !m_level[b]) begin
                    cand[b]     = 1'b1;
                    press_at[b] = cyc;
                end else if (!m_stable[b]) begin
                    press_at[b] = -1;
                end else if (RPT_MASK[b] && press_at[b] >= 0 &&
                             cyc - press_at[b] >= RDELAY &&
                             (cyc - press_at[b] - RDELAY) % RRATE == 0) begin
                    cand[b] = 1'b1;
                end
            end
            win = '0;
            for (int b = 4; b >= 0; b--)
                if (cand[b]) win = 5'(1 << b);
            e.ev  = win;
            e.lv  = m_stable;
            e.any = |win;
            m_level  = m_stable;
            m_stable = st_new;
            for (int j = DEB; j >= 1; j--) hist[j] = hist[j-1];
            hist[0] = btn_raw;
        end
        expq.push_back(e);
    end

    // Monitor: one comparison per cycle, mid-cycle.
    initial begin
        exp_t e;
        for (int b = 0; b < 5; b++) evt_seen[b] = 0;
        @(posedge clk_200_hz);
        forever begin
            @(negedge clk_200_hz);
            n_checks++;
            if (expq.size() == 0) begin
                $display("FAIL scoreboard_empty at cycle %0d", cyc);
            end else begin
                e = expq.pop_front();
                if (rst) e = '0;
                if ({btn_event, btn_level, any_event} === e) begin
                    n_pass++;
                end else begin
                    $display("FAIL cycle_%0d: event=%b level=%b any=%b want event=%b level=%b any=%b",
                             cyc, btn_event, btn_level, any_event, e.ev, e.lv, e.any);
                end
                if (!rst)
                    for (int b = 0; b < 5; b++)
                        if (btn_event[b]) evt_seen[b]++;
            end
        end
    end

    task automatic step(input logic [4:0] v, input int n);
        btn_raw = v;
        repeat (n) begin
            @(posedge clk_200_hz);
            #2;
        end
    endtask

    task automatic check_cnt(input string name, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d events, want %0d", name, got, want);
    endtask

    initial begin
        int base [5];
        logic [4:0] v;
        rst     = 1'b1;
        btn_raw = '0;
        repeat (3) @(posedge clk_200_hz);
        #2;
        rst = 1'b0;
        step('0, 5);

        // Bounced press of C
        base = evt_seen;
        step(B_C, 1); step('0, 1); step(B_C, 1);
        step(B_C, 10);
        step('0, 20);
        check_cnt("bounce_c", evt_seen[0] - base[0], 1);

        // Short glitch on R
        base = evt_seen;
        step(B_R, 3);
        step('0, 20);
        check_cnt("glitch_r", evt_seen[2] - base[2], 0);

        // Held U auto-repeats
        base = evt_seen;
        step(B_U, 200);
        step('0, 150);
        check_cnt("repeat_u", evt_seen[4] - base[4], 6);

        // Held L gives one event
        base = evt_seen;
        step(B_L, 300);
        step('0, 20);
        check_cnt("hold_l", evt_seen[1] - base[1], 1);

        // C and U together: C wins the press, U still repeats
        base = evt_seen;
        step(B_C | B_U, 130);
        step('0, 20);
        check_cnt("simul_c", evt_seen[0] - base[0], 1);
        check_cnt("simul_u", evt_seen[4] - base[4], 2);

        // Reset while D is held, D stays held across release
        base = evt_seen;
        step(B_D, 116);
        rst = 1'b1;
        step(B_D, 2);
        rst = 1'b0;
        step(B_D, 20);
        step('0, 20);
        check_cnt("reset_d", evt_seen[3] - base[3], 3);

        // Random activity
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 9) < 6) v = 5'(1 << $urandom_range(0, 4));
            else v = 5'($urandom_range(1, 31));
            for (int k = 0; k < int'($urandom_range(0, 4)); k++)
                step(5'($urandom) & v, 1);
            step(v, $urandom_range(1, 160));
            step('0, $urandom_range(1, 30));
            if ($urandom_range(0, 9) == 0) begin
                rst = 1'b1;
                step(btn_raw, $urandom_range(1, 2));
                rst = 1'b0;
            end
        end
        step('0, 20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
